// File: rtl/prefix_add_arbiter_if.sv
// rtl/prefix_add_arbiter_if.sv - requester/response bundle for the prefix adder arbiter
//
// Signals:
//   req_valid/req_ready  per-requester handshake (NREQ bits)
//   req_a/req_b          packed 8-bit operands, requester i in [8i+7:8i]
//   rsp_valid/rsp_ready  result handshake
//   rsp_sum/rsp_cout     registered 9-bit result
//   rsp_id               index of the requester that produced the result
//   grant_cnt            accepted-transaction count, wraps modulo 2^16
// Modports: master = requesters plus result consumer, slave = arbiter.

interface prefix_add_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       grant_cnt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, grant_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, grant_cnt
    );
endinterface

// File: rtl/prefix_add_arbiter.sv
// rtl/prefix_add_arbiter.sv - round-robin arbiter sharing one 8-bit prefix adder
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  prefix_add_arbiter_if.slave (request/response handshakes and counters)
//
// One requester per cycle is granted in round-robin order starting after the
// last granted index. The granted operands feed a single Kogge-Stone adder and
// the result is registered with one cycle of latency. A pending result blocks
// new grants unless it is drained in the same cycle, which keeps one result per
// cycle under full load.

module GPTPrefix8_L8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);
    // gs/ps[s] hold group generate/propagate after s combining levels
    // (spans 1, 2, 4, 8 bits); carry-in is zero so G[i] is the carry into bit i+1.
    logic [7:0] gs [0:3];
    logic [7:0] ps [0:3];

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            gs[s] = '0;
            ps[s] = '0;
        end
        gs[0] = a & b;
        ps[0] = a ^ b;
        for (int s = 1; s < 4; s++) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= (1 << (s - 1))) begin
                    gs[s][i] = gs[s-1][i] | (ps[s-1][i] & gs[s-1][i - (1 << (s - 1))]);
                    ps[s][i] = ps[s-1][i] & ps[s-1][i - (1 << (s - 1))];
                end else begin
                    gs[s][i] = gs[s-1][i];
                    ps[s][i] = ps[s-1][i];
                end
            end
        end
        sum  = ps[0] ^ {gs[3][6:0], 1'b0};
        cout = gs[3][7];
    end
endmodule

module prefix_add_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic               clk,
    input logic               rst,
    prefix_add_arbiter_if.slave bus
);
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  win_idx;
    logic            win_found;
    logic            can_accept;
    logic            xfer;
    logic [NREQ-1:0] grant;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic [7:0]      add_sum;
    logic            add_cout;
    int              idx;

    // Winner search looks only at req_valid and last_grant so req_ready never
    // depends on operand data.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    // rst gates acceptance so nothing is offered while in reset.
    assign can_accept = !rst && (!bus.rsp_valid || bus.rsp_ready);

    always_comb begin
        grant = '0;
        if (can_accept && win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign bus.req_ready = grant;
    assign xfer          = |(grant & bus.req_valid);

    assign op_a = bus.req_a[int'(win_idx)*8 +: 8];
    assign op_b = bus.req_b[int'(win_idx)*8 +: 8];

    GPTPrefix8_L8 u_adder (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= 8'h00;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_id    <= '0;
            bus.grant_cnt <= 16'h0000;
            last_grant    <= IDW'(NREQ - 1);
        end else if (xfer) begin
            // A grant implies the old result (if any) drains this cycle, so
            // overwriting keeps rsp_valid high without a bubble.
            bus.rsp_valid <= 1'b1;
            bus.rsp_sum   <= add_sum;
            bus.rsp_cout  <= add_cout;
            bus.rsp_id    <= win_idx;
            bus.grant_cnt <= bus.grant_cnt + 16'd1;
            last_grant    <= win_idx;
        end else if (bus.rsp_ready) begin
            // Drain only; result data stays at its last value.
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prefix_add_arbiter.sv
// tb/tb_prefix_add_arbiter.sv - randomized self-checking bench with reference model

module tb_prefix_add_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prefix_add_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    prefix_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // reference state
    int         m_last;
    logic       m_valid;
    logic [7:0] m_sum;
    logic       m_cout;
    int         m_id;
    int         m_cnt;

    logic [3:0] obs_ready;
    logic [3:0] exp_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_ready(input logic [3:0] v, input logic rr, input logic r);
        logic [3:0] res;
        res = 4'b0000;
        if (!r && (!m_valid || rr)) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (res == 4'b0000 && v[i]) res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // One clock: drive inputs after the falling edge, check ready, advance the
    // model on the rising edge, then check registered outputs on the next fall.
    task automatic cycle(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic rr, input logic r);
        int w;
        rst           = r;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rr;
        #1;
        exp_ready = model_ready(v, rr, r);
        obs_ready = bus.req_ready;
        check("req_ready", 32'(obs_ready), 32'(exp_ready));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_sum = 8'h00; m_cout = 1'b0; m_id = 0; m_cnt = 0;
            m_last  = NREQ - 1;
        end else if (exp_ready != 4'b0000) begin
            int s;
            w = 0;
            for (int i = 0; i < NREQ; i++) if (exp_ready[i]) w = i;
            s = int'(a[w*8 +: 8]) + int'(b[w*8 +: 8]);
            m_sum   = s[7:0];
            m_cout  = s[8];
            m_id    = w;
            m_valid = 1'b1;
            m_last  = w;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        check("rsp_sum",   32'(bus.rsp_sum),   32'(m_sum));
        check("rsp_cout",  32'(bus.rsp_cout),  32'(m_cout));
        check("rsp_id",    32'(bus.rsp_id),    32'(m_id));
        check("grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        cycle(4'($urandom), $urandom, $urandom, 1'($urandom), 1'b1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int order [6];
        order = '{0, 1, 2, 3, 0, 1};
        m_last = NREQ - 1; m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = 0; m_cnt = 0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        @(negedge clk);
        do_reset();
        do_reset();
        check("reset_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_cnt",   32'(bus.grant_cnt), 32'd0);

        // single request
        cycle(4'b0001, 32'h000000FF, 32'h00000001, 1'b1, 1'b0);
        check("single_ready", 32'(obs_ready), 32'h1);
        check("single_sum",   32'(bus.rsp_sum), 32'h00);
        check("single_cout",  32'(bus.rsp_cout), 32'h1);
        check("single_id",    32'(bus.rsp_id), 32'h0);
        check("single_cnt",   32'(bus.grant_cnt), 32'h1);
        cycle(4'b0000, $urandom, $urandom, 1'b1, 1'b0);
        check("single_drain", 32'(bus.rsp_valid), 32'h0);

        // saturation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, $urandom, $urandom, 1'b1, 1'b0);
            check("sat_grant", 32'(obs_ready), 32'(1 << order[i]));
            check("sat_id", 32'(bus.rsp_id), 32'(order[i]));
            check("sat_valid", 32'(bus.rsp_valid), 32'h1);
        end

        // backpressure
        do_reset();
        cycle(4'b0001, 32'h0000007F, 32'h00000001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, $urandom, $urandom, 1'b0, 1'b0);
            check("bp_ready", 32'(obs_ready), 32'h0);
            check("bp_sum",   32'(bus.rsp_sum), 32'h80);
            check("bp_cout",  32'(bus.rsp_cout), 32'h0);
        end
        cycle(4'b1111, $urandom, $urandom, 1'b1, 1'b0);
        check("bp_release", 32'(obs_ready), 32'h2);

        // sparse requests after last_grant=1
        do_reset();
        cycle(4'b0010, $urandom, $urandom, 1'b1, 1'b0);
        cycle(4'b1001, $urandom, $urandom, 1'b1, 1'b0);
        check("sparse_first", 32'(obs_ready), 32'h8);
        cycle(4'b1001, $urandom, $urandom, 1'b1, 1'b0);
        check("sparse_second", 32'(obs_ready), 32'h1);

        // reset with result pending
        cycle(4'b1111, $urandom, $urandom, 1'b0, 1'b0);
        cycle(4'b1111, $urandom, $urandom, 1'b0, 1'b1);
        check("midrst_valid", 32'(bus.rsp_valid), 32'h0);
        check("midrst_cnt",   32'(bus.grant_cnt), 32'h0);
        cycle(4'b1111, $urandom, $urandom, 1'b1, 1'b0);
        check("midrst_first", 32'(obs_ready), 32'h1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            ra = $urandom; rb = $urandom;
            cycle(4'($urandom), ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        // counter wrap
        do_reset();
        for (int i = 0; i < 65535; i++) cycle(4'b1111, $urandom, $urandom, 1'b1, 1'b0);
        check("wrap_ffff", 32'(bus.grant_cnt), 32'hFFFF);
        cycle(4'b1111, $urandom, $urandom, 1'b1, 1'b0);
        check("wrap_zero", 32'(bus.grant_cnt), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prefix_add_arbiter.md
PREFIX_ADD_ARBITER -- requirements
Module: prefix_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the adder (legal range 2..8).
REQ-002 SHALL have parameter IDW, default 2, width of requester ID (= ceil(log2(NREQ)), minimum 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand-valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a  input  NREQ*8  operand A, requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_b  input  NREQ*8  operand B, same packing as req_a.
REQ-009 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-010 SHALL have port rsp_ready  input  1  downstream consumes result.
REQ-011 SHALL have port rsp_sum  output  8  registered sum.
REQ-012 SHALL have port rsp_cout  output  1  registered carry-out.
REQ-013 SHALL have port rsp_id  output  IDW  index of requester that produced the result.
REQ-014 SHALL have port grant_cnt  output  16  count of accepted transactions, wraps modulo 2^16.

Function
REQ-015 SHALL instantiate exactly one GPTPrefix8_L8 (8-bit prefix adder, carry-in 0); its inputs SHALL be driven by a mux selecting the granted requester's operands.
REQ-016 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 The block SHALL be able to accept ("can_accept") when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 in the same cycle.
REQ-018 req_ready SHALL be combinational: one-hot for the round-robin winner among asserted req_valid bits when can_accept=1, otherwise all zero.
REQ-019 Round-robin: the search SHALL start at index (last_grant+1) mod NREQ and ascend with wrap-around; the first asserted req_valid wins.
REQ-020 last_grant SHALL update only on a transfer and SHALL be unchanged in idle cycles.
REQ-021 Latency SHALL be one cycle: a transfer at edge N loads rsp_sum, rsp_cout and rsp_id and sets rsp_valid, all visible after edge N.
REQ-022 rsp_sum, rsp_cout = low 8 bits and bit 8 of a+b (unsigned, 9-bit result).
REQ-023 With rsp_valid=1 and rsp_ready=0, rsp_* SHALL hold stable and req_ready SHALL be all zero.
REQ-024 On rsp_valid=1, rsp_ready=1 and no new transfer, rsp_valid SHALL clear; rsp_sum, rsp_cout and rsp_id SHALL retain their last value.
REQ-025 On simultaneous drain and transfer, the new result SHALL replace the old without a bubble, keeping rsp_valid=1 (full throughput: one result per cycle).
REQ-026 req_ready SHALL NOT depend on req_a or req_b; it SHALL depend only on req_valid, rsp_valid, rsp_ready and last_grant.
REQ-027 grant_cnt SHALL increment by 1 on each transfer and wrap from 0xFFFF to 0x0000.
REQ-028 Requests whose req_valid drops before grant SHALL be ignored; no request SHALL be latched without a transfer.

Reset
REQ-029 While rst=1 at a clock edge: rsp_valid=0, rsp_sum=0x00, rsp_cout=0, rsp_id=0, grant_cnt=0, and last_grant=NREQ-1, so requester 0 has first priority.
REQ-030 req_ready SHALL be all zero in any cycle where rst=1.
REQ-031 Reset asserted with a result pending SHALL discard it; no rsp_valid SHALL appear after reset until a new transfer.

Verification
REQ-032 Single request: req_valid=0001, a0=0xFF, b0=0x01, rsp_ready=1 -> req_ready=0001 for one cycle; next cycle rsp_valid=1, rsp_sum=0x00, rsp_cout=1, rsp_id=0, grant_cnt=1.
REQ-033 Saturation: req_valid=1111 held, rsp_ready=1 after reset -> grant order 0,1,2,3,0,1 on consecutive cycles; rsp_valid stays high and rsp_id follows the same order one cycle later.
REQ-034 Backpressure: result 0x7F+0x01 pending (sum 0x80, cout 0), rsp_ready=0 for 5 cycles with req_valid=1111 -> outputs stable, req_ready=0000; on rsp_ready=1, the next winner is granted in the same cycle.
REQ-035 Sparse requests: last_grant=1, req_valid=1001 -> requester 3 granted first, then requester 0.
REQ-036 Reset mid-operation: rst=1 while rsp_valid=1 -> next cycle rsp_valid=0, grant_cnt=0; first post-reset grant with req_valid=1111 goes to requester 0.
REQ-037 Counter wrap: grant_cnt forced to 0xFFFF via 65535 transfers, then one more transfer -> grant_cnt=0x0000.
